// File: rtl/cpu_types_pkg.sv
// Shared cache-controller types, the hit-count dump address and the
// address-geometry helpers used to split a byte address into tag/index/offset.
package cpu_types_pkg;

  typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH, CNT, DONE} dstate_t;

  localparam logic [31:0] HITCNT_ADDR = 32'h0000_3100;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned words);
    return 32'd30 - idx_w(sets) - off_w(words);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One way of the data cache: valid/dirty/tag/data storage plus the tag compare
// for the currently addressed set.
module dcache_way
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WORDS = 2
) (
  input  logic                              CLK,
  input  logic                              nRST,
  input  logic [idx_w(SETS)-1:0]            idx,
  input  logic [off_w(WORDS)-1:0]           off,
  input  logic [tag_w(SETS, WORDS)-1:0]     tag_in,
  input  logic                              wr_en,
  input  logic [31:0]                       wr_data,
  input  logic                              wr_dirty,
  input  logic                              fill_done,
  input  logic                              inval,
  output logic                              hit,
  output logic                              valid,
  output logic                              dirty,
  output logic [tag_w(SETS, WORDS)-1:0]     tag,
  output logic [31:0]                       rdata
);

  localparam int unsigned TW = tag_w(SETS, WORDS);

  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS][WORDS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inval) begin
      valid_q[idx] <= 1'b0;
      dirty_q[idx] <= 1'b0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (wr_en && wr_dirty) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data are plain storage; the valid bit qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_done) tag_q[idx] <= tag_in;
    if (wr_en)     data_q[idx][off] <= wr_data;
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign rdata = data_q[idx][off];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag_in);

endmodule

// File: rtl/dcache_wb.sv
// 2-way set-associative write-back, write-allocate data cache with LRU
// replacement, halt-triggered flush and hit-count dump.
module dcache_wb
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WORDS = 2,
  parameter int unsigned CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int unsigned IW = idx_w(SETS);
  localparam int unsigned OW = off_w(WORDS);
  localparam int unsigned TW = tag_w(SETS, WORDS);
  localparam logic [OW-1:0] LAST = OW'(WORDS - 1);
  localparam int unsigned unused_cpuid = CPUID;

  dstate_t       state, next_state;
  logic [OW-1:0] cnt, cnt_n;
  logic [IW:0]   scan, scan_n;
  logic          victim, victim_n;
  logic [TW-1:0] vtag, vtag_n;
  logic [31:0]   hitcnt;
  logic          after_fill;
  logic [SETS-1:0] lru;

  logic [TW-1:0] req_tag;
  logic [IW-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic          req, is_wr, hit_way, fway, line_done;
  logic          unused_bits;

  logic [1:0]    hit_w, valid_w, dirty_w, wr_en_w, fill_w, inval_w;
  logic [TW-1:0] way_tag [2];
  logic [31:0]   rdata_w [2];
  logic [IW-1:0] way_idx;
  logic [OW-1:0] way_off;
  logic [31:0]   wr_data;
  logic          wr_dirty;

  assign req_off     = dmemaddr[2 +: OW];
  assign req_idx     = dmemaddr[2 + OW +: IW];
  assign req_tag     = dmemaddr[31 -: TW];
  assign unused_bits = ^dmemaddr[1:0];
  assign req         = dmemREN | dmemWEN;
  assign is_wr       = dmemWEN & ~dmemREN;
  assign hit_way     = hit_w[1];
  assign fway        = scan[0];

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way #(.SETS(SETS), .WORDS(WORDS)) u_way (
      .CLK(CLK), .nRST(nRST), .idx(way_idx), .off(way_off), .tag_in(req_tag),
      .wr_en(wr_en_w[w]), .wr_data(wr_data), .wr_dirty(wr_dirty),
      .fill_done(fill_w[w]), .inval(inval_w[w]),
      .hit(hit_w[w]), .valid(valid_w[w]), .dirty(dirty_w[w]),
      .tag(way_tag[w]), .rdata(rdata_w[w])
    );
  end

  always_comb begin
    next_state = state;
    cnt_n      = cnt;
    scan_n     = scan;
    victim_n   = victim;
    vtag_n     = vtag;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed    = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    way_idx    = req_idx;
    way_off    = cnt;
    wr_data    = dload;
    wr_dirty   = 1'b0;
    wr_en_w    = '0;
    fill_w     = '0;
    inval_w    = '0;
    line_done  = 1'b0;
    unique case (state)
      IDLE: begin
        way_off = req_off;
        if (req && (|hit_w)) begin
          dhit     = 1'b1;
          dmemload = rdata_w[hit_way];
          if (is_wr) begin
            wr_en_w[hit_way] = 1'b1;
            wr_data          = dmemstore;
            wr_dirty         = 1'b1;
          end
        end else if (req) begin
          victim_n   = !valid_w[0] ? 1'b0 : (!valid_w[1] ? 1'b1 : lru[req_idx]);
          vtag_n     = way_tag[victim_n];
          cnt_n      = '0;
          next_state = (valid_w[victim_n] && dirty_w[victim_n]) ? WB : FILL;
        end else if (halt) begin
          scan_n     = '0;
          cnt_n      = '0;
          next_state = FLUSH;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {vtag, req_idx, cnt, 2'b00};
        dstore = rdata_w[victim];
        if (!dwait) begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) next_state = FILL;
        end
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {req_tag, req_idx, cnt, 2'b00};
        if (!dwait) begin
          wr_en_w[victim] = 1'b1;
          cnt_n           = cnt + 1'b1;
          if (cnt == LAST) begin
            fill_w[victim] = 1'b1;
            next_state     = IDLE;
          end
        end
      end
      FLUSH: begin
        // scan = {set, way}: set-major, way 0 first.
        way_idx = scan[IW:1];
        if (valid_w[fway] && dirty_w[fway]) begin
          dWEN   = 1'b1;
          daddr  = {way_tag[fway], scan[IW:1], cnt, 2'b00};
          dstore = rdata_w[fway];
          if (!dwait) begin
            cnt_n = cnt + 1'b1;
            if (cnt == LAST) line_done = 1'b1;
          end
        end else begin
          line_done = 1'b1;
        end
        if (line_done) begin
          inval_w[fway] = 1'b1;
          if (&scan) next_state = CNT;
          else       scan_n     = scan + 1'b1;
        end
      end
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt;
        if (!dwait) next_state = DONE;
      end
      DONE: flushed = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      cnt        <= '0;
      scan       <= '0;
      victim     <= 1'b0;
      vtag       <= '0;
      hitcnt     <= '0;
      after_fill <= 1'b0;
      lru        <= '0;
    end else begin
      state  <= next_state;
      cnt    <= cnt_n;
      scan   <= scan_n;
      victim <= victim_n;
      vtag   <= vtag_n;
      // The hit that completes a miss is not counted as a cache hit.
      if (state == FILL && !dwait && cnt == LAST) begin
        after_fill <= 1'b1;
      end else if (dhit) begin
        after_fill <= 1'b0;
        if (!after_fill && hitcnt != '1) hitcnt <= hitcnt + 1'b1;
      end
      if (dhit) lru[req_idx] <= ~hit_way;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: fills, dirty eviction, stalled fill, flush with
// hit-count dump, and reset in the middle of a write-back.
module tb_dcache_wb;

  localparam int unsigned SETS  = 8;
  localparam int unsigned WORDS = 2;
  localparam logic [31:0] BLK   = 32'(WORDS * 4);
  localparam logic [31:0] SPAN  = 32'(SETS * WORDS * 4);

  logic        CLK = 1'b0;
  logic        nRST, dmemREN, dmemWEN, halt;
  logic [31:0] dmemaddr, dmemstore;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore, dload;
  logic        dwait = 1'b0;

  dcache_wb #(.SETS(SETS), .WORDS(WORDS), .CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait)
  );

  always #5 CLK = ~CLK;

  // Memory model: read data is a fixed function of the address.
  function automatic logic [31:0] memv(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction
  assign dload = memv(daddr);

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_wr[$];
  int unsigned mem_cycles = 0;
  logic        stall_mode = 1'b0;
  int unsigned wcnt = 0;
  logic        prev_wait = 1'b0;
  logic        prev_ren = 1'b0;
  logic [31:0] prev_addr = '0;

  // Stall generator: five wait cycles before each memory word is accepted.
  always @(negedge CLK) begin
    if (stall_mode && nRST && (dREN || dWEN)) begin
      if (wcnt < 5) begin dwait = 1'b1; wcnt++; end
      else          begin dwait = 1'b0; wcnt = 0; end
    end else begin
      dwait = 1'b0;
      wcnt  = 0;
    end
  end

  always @(negedge CLK) begin
    #2;
    if (nRST && (dREN || dWEN)) begin
      mem_cycles++;
      if (!dwait) begin
        log_addr.push_back(daddr);
        log_data.push_back(dstore);
        log_wr.push_back(dWEN);
      end
    end
    if (stall_mode && prev_wait) begin
      chk("stall_addr", daddr, prev_addr);
      chk("stall_ren", 32'(dREN), 32'(prev_ren));
    end
    prev_wait = dwait && (dREN || dWEN);
    prev_addr = daddr;
    prev_ren  = dREN;
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_wr.delete();
    mem_cycles = 0;
  endtask

  // Present one request, hold it until dhit, return read data, memory-busy
  // cycles seen before the hit and cycles waited.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] ld, output int unsigned mc, output int unsigned wt);
    clear_log();
    dmemREN = rd; dmemWEN = wr; dmemaddr = a; dmemstore = d;
    wt = 0;
    #1;
    while (!dhit && wt < 300) begin
      @(negedge CLK); #1;
      wt++;
    end
    chk("dhit_reached", 32'(dhit), 32'd1);
    ld = dmemload;
    mc = mem_cycles;
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic burst(input string tag, input int unsigned first, input logic wr, input logic [31:0] base);
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (first + k < 32'(log_addr.size())) begin
        chk({tag, "_addr"}, log_addr[first + k], base + 32'(4 * k));
        chk({tag, "_dir"}, 32'(log_wr[first + k]), 32'(wr));
      end else begin
        chk({tag, "_count"}, 32'(log_addr.size()), 32'(first + k + 1));
      end
    end
  endtask

  initial begin
    logic [31:0] ld, s7, sa, a;
    int unsigned mc, wt, n;

    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0;
    dmemaddr = '0; dmemstore = '0;
    @(negedge CLK); #1;
    chk("rst_ctl", {28'b0, dhit, dREN, dWEN, flushed}, 32'd0);
    chk("rst_daddr", daddr, 32'd0);
    chk("rst_dstore", dstore, 32'd0);
    chk("rst_load", dmemload, 32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);

    // Cold read miss, then hits on both words of the line.
    access(1'b1, 1'b0, SPAN, '0, ld, mc, wt);
    chk("fill_load", ld, memv(SPAN));
    chk("fill_cycles", 32'(mc), 32'(WORDS));
    burst("fill", 0, 1'b0, SPAN);
    access(1'b1, 1'b0, SPAN, '0, ld, mc, wt);
    chk("rehit_load", ld, memv(SPAN));
    chk("rehit_wait", 32'(wt), 32'd0);
    chk("rehit_mem", 32'(mc), 32'd0);
    access(1'b1, 1'b0, SPAN + 32'd4, '0, ld, mc, wt);
    chk("hit_w1_load", ld, memv(SPAN + 32'd4));
    access(1'b0, 1'b1, SPAN, 32'h0000_1234, ld, mc, wt);
    chk("wrhit_wait", 32'(wt), 32'd0);

    // Fill way 1, then evict the dirty way-0 line.
    access(1'b1, 1'b0, 2 * SPAN, '0, ld, mc, wt);
    chk("way1_load", ld, memv(2 * SPAN));
    chk("way1_cycles", 32'(mc), 32'(WORDS));
    access(1'b1, 1'b0, 3 * SPAN, '0, ld, mc, wt);
    chk("evict_load", ld, memv(3 * SPAN));
    chk("evict_cycles", 32'(mc), 32'(2 * WORDS));
    burst("evict_wb", 0, 1'b1, SPAN);
    burst("evict_fill", WORDS, 1'b0, 3 * SPAN);
    for (int unsigned k = 0; k < WORDS; k++)
      if (k < 32'(log_data.size()))
        chk("evict_data", log_data[k], (k == 0) ? 32'h0000_1234 : memv(SPAN + 32'(4 * k)));
    access(1'b1, 1'b0, SPAN, '0, ld, mc, wt);
    chk("clean_evict_cycles", 32'(mc), 32'(WORDS));

    // Both enables high behaves as a read.
    access(1'b1, 1'b1, 3 * SPAN + 32'd4, 32'hDEAD_BEEF, ld, mc, wt);
    chk("both_load", ld, memv(3 * SPAN + 32'd4));
    access(1'b0, 1'b1, 3 * SPAN, 32'h0000_0077, ld, mc, wt);

    // Stalled fill.
    sa = 5 * SPAN + 3 * BLK;
    stall_mode = 1'b1;
    access(1'b1, 1'b0, sa, '0, ld, mc, wt);
    stall_mode = 1'b0;
    chk("stall_cycles", 32'(mc), 32'(6 * WORDS));
    chk("stall_load", ld, memv(sa));
    burst("stall_fill", 0, 1'b0, sa);

    // Write miss in the last set leaves a dirty line there.
    s7 = SPAN + BLK * 32'(SETS - 1);
    access(1'b0, 1'b1, s7, 32'h0000_0055, ld, mc, wt);
    chk("wrmiss_cycles", 32'(mc), 32'(WORDS));

    // Flush: set 0 way 0 then last set way 0, then the hit count.
    clear_log();
    halt = 1'b1;
    n = 0;
    while (!flushed && n < 20 * SETS + 50) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("flushed", 32'(flushed), 32'd1);
    chk("flush_writes", 32'(log_addr.size()), 32'(2 * WORDS + 1));
    burst("flush_set0", 0, 1'b1, 3 * SPAN);
    burst("flush_setN", WORDS, 1'b1, s7);
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (WORDS + k < 32'(log_data.size())) begin
        chk("flush0_data", log_data[k], (k == 0) ? 32'h0000_0077 : memv(3 * SPAN + 32'(4 * k)));
        chk("flushN_data", log_data[WORDS + k], (k == 0) ? 32'h0000_0055 : memv(s7 + 32'(4 * k)));
      end
    end
    if (log_addr.size() == 2 * WORDS + 1) begin
      chk("cnt_addr", log_addr[2 * WORDS], 32'h0000_3100);
      chk("cnt_data", log_data[2 * WORDS], 32'd5);
    end
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = SPAN;
    @(negedge CLK); #1;
    chk("done_ctl", {28'b0, dhit, dREN, dWEN, flushed}, 32'd1);
    dmemREN = 1'b0; halt = 1'b0;

    // Reset in the middle of a write-back.
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    access(1'b0, 1'b1, SPAN, 32'h0000_0099, ld, mc, wt);
    access(1'b1, 1'b0, 2 * SPAN, '0, ld, mc, wt);
    a = 3 * SPAN;
    dmemREN = 1'b1; dmemaddr = a;
    n = 0;
    #1;
    while (!dWEN && n < 10) begin
      @(negedge CLK); #1;
      n++;
    end
    chk("wb_started", 32'(dWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("midrst_ctl", {28'b0, dhit, dREN, dWEN, flushed}, 32'd0);
    chk("midrst_daddr", daddr, 32'd0);
    chk("midrst_dstore", dstore, 32'd0);
    chk("midrst_load", dmemload, 32'd0);
    @(negedge CLK);
    dmemREN = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    access(1'b1, 1'b0, a, '0, ld, mc, wt);
    chk("post_rst_miss", 32'(mc), 32'(WORDS));
    chk("post_rst_load", ld, memv(a));
    access(1'b1, 1'b0, SPAN, '0, ld, mc, wt);
    chk("post_rst_miss2", 32'(mc), 32'(WORDS));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_wb.md
DCACHE_WB -- requirements
Module: dcache_wb

Interface
REQ-001 Parameter SETS, default 8, number of sets (power of 2, >=2).
REQ-002 Parameter WORDS, default 2, 32-bit words per block (power of 2, >=2).
REQ-003 Parameter CPUID, default 0, core identifier (no functional effect).
REQ-004 Port CLK in 1, clock, rising edge; nRST in 1, reset, asynchronous, active-low.
REQ-005 Ports dmemREN in 1 and dmemWEN in 1, datapath read/write request, held until dhit.
REQ-006 Ports dmemaddr in 32, word-aligned byte address, and dmemstore in 32, store data.
REQ-007 Port halt in 1, request a full write-back flush; level, held.
REQ-008 Ports dhit out 1 (request complete) and dmemload out 32 (read data, valid with dhit).
REQ-009 Port flushed out 1, flush complete; sticky until reset.
REQ-010 Ports dREN out 1, dWEN out 1, daddr out 32, dstore out 32, memory request.
REQ-011 Ports dload in 32, memory read data, and dwait in 1, high while memory busy.

Function
REQ-012 Address split: [1:0] byte, next log2(WORDS) bits block offset, next log2(SETS) bits index, remaining upper bits tag.
REQ-013 Organisation: 2-way set-associative, write-back, write-allocate; per line valid, dirty, tag, WORDS data words; one LRU bit per set.
REQ-014 Read hit in IDLE: dhit=1 and dmemload=hit word in the same cycle, combinational; LRU points to other way.
REQ-015 Write hit in IDLE: dhit=1 same cycle; word written and dirty set at next edge; LRU points to other way.
REQ-016 Miss: victim=invalid way if any (way0 first), else LRU way; victim read once on entering the miss path, fixed until the miss completes.
REQ-017 States: IDLE, WB, FILL, FLUSH, CNT, DONE.
REQ-018 IDLE->WB on miss with valid dirty victim; IDLE->FILL on miss with clean/invalid victim; IDLE->FLUSH on halt with no request pending.
REQ-019 WB: dWEN=1, daddr={victim tag,index,word counter,00}, dstore=victim word; counter advances when dwait=0; after WORDS words ->FILL.
REQ-020 FILL: dREN=1, daddr={request tag,index,word counter,00}; word captured when dwait=0; after WORDS words line valid, clean, tag updated ->IDLE; request then hits.
REQ-021 Miss latency with dwait=0 throughout: WORDS cycles (clean) or 2*WORDS cycles (dirty) before the hit cycle.
REQ-022 Hit counter: 32-bit, +1 per dhit cycle that did not follow a miss fill; -1 never; saturates at 0xFFFFFFFF.
REQ-023 FLUSH: scans all SETS*2 lines in set-major, way0 first order; each valid dirty line written back word by word as WB; clean/invalid lines skipped at one per cycle; each line cleared invalid.
REQ-024 CNT: dWEN=1, daddr=0x00003100, dstore=hit counter, held until dwait=0 ->DONE.
REQ-025 DONE: flushed=1, dhit=0, no memory requests; remains until reset.
REQ-026 dREN and dWEN never both 1; all memory outputs 0 outside WB/FILL/FLUSH-writeback/CNT.
REQ-027 dmemREN and dmemWEN both high: treated as read.
REQ-028 halt while a miss is in progress: miss completes first, flush begins from IDLE.

Reset
REQ-029 nRST low: state IDLE, all valid/dirty/LRU bits 0, counters 0, all outputs 0, effective immediately, mid-transfer transactions abandoned.

Structure
REQ-030 State enum and address-field width functions live in cpu_types_pkg; 0x3100 hit-count address constant in the same package.
REQ-031 One sub-module, dcache_way, holds one way's storage (valid/dirty/tag/data arrays) and hit compare, instantiated twice.

Verification
REQ-032 Reset, read 0x40 (dload=0xAAAA_0000+addr) -> FILL reads 0x40,0x44; dhit with 0xAAAA0040; re-read -> dhit same cycle.
REQ-033 Write 0x1234 to 0x40 after fill, then two reads mapping to index 0 with different tags -> second evicts way0 with WB of 0x40=0x1234, 0x44 before FILL.
REQ-034 Hold dwait=1 for 5 cycles per word during FILL -> daddr/dREN stable, dhit only after last word.
REQ-035 Dirty lines in sets 0 and 7, halt -> exactly 2*WORDS writes then write 0x3100=hit count, flushed=1.
REQ-036 Assert nRST mid-WB -> all outputs 0 next sample, subsequent read of same address misses.
REQ-037 SETS=16, WORDS=4 build: fill/evict/flush scenarios pass with 4-word bursts.
